icache_direct: RTL and testbench
================================

// Module: icache_direct
// PURPOSE
//  Direct-mapped instruction cache between the fetcher and the byte-serial memory controller.
//  Drives the memory controller's icache request port: in_icache_ena/addr, out_icache_ok/data.
//  Hits return a 32-bit instruction one cycle after the request.
//  Misses issue one word read to memory, fill the line, then answer the fetcher.
// PARAMETERS
//  INDEX_BITS  6   log2(number of lines); one 32-bit word per line
//  STAT_WIDTH  32  width of hit/miss counters (ICACHE_STATS_EN only)
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  in_flush        in   1   mispredict flush; squash pending fetch answer
//  in_fetch_ena    in   1   fetch request, level, held until out_fetch_ok
//  in_fetch_addr   in   32  fetch PC; bits[1:0] ignored
//  out_fetch_ok    out  1   one-cycle pulse, instruction valid
//  out_fetch_inst  out  32  instruction; ZERO_DATA when ok low
//  out_mem_ena     out  1   memory read request, one-cycle pulse
//  out_mem_addr    out  32  word-aligned miss address
//  in_mem_busy     in   1   memory controller busy
//  in_mem_ok       in   1   memory read-done pulse
//  in_mem_data     in   32  memory read data, valid with in_mem_ok
//  out_hit_cnt     out  STAT_WIDTH  hits (ICACHE_STATS_EN only)
//  out_miss_cnt    out  STAT_WIDTH  misses (ICACHE_STATS_EN only)
// BEHAVIOUR
//  - Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2].
//  - Storage: valid[], tag[], data[] arrays.
//  - Reset clears all valid bits and returns the FSM to IDLE. Tag/data arrays are not reset.
//  - Reset values: out_fetch_ok=0, out_fetch_inst=0, out_mem_ena=0, out_mem_addr=0.
//  - Reset mid-miss: FSM returns to IDLE. A later in_mem_ok is ignored; nothing is written.
//  - Registered outputs: out_fetch_ok, out_fetch_inst and out_mem_ena default to 0 every cycle.
//  - FSM states: IDLE, ISSUE, WAIT, RESP.
//  - IDLE, fetch_ena=1, hit, no flush: next cycle ok=1, inst=data[index]; stay IDLE.
//  - IDLE, ok cycle: a request still high in the cycle ok is driven is not looked up.
//    The fetcher drops ena on ok; back-to-back hits therefore occur every 2 cycles.
//  - IDLE, miss: latch word-aligned addr in miss_addr; go to ISSUE.
//  - ISSUE, in_mem_busy=0: pulse out_mem_ena=1 for exactly one cycle with out_mem_addr=miss_addr; go to WAIT.
//    The controller grants icache priority when idle, so the pulse is always accepted.
//  - ISSUE, in_mem_busy=1: wait; no pulse.
//  - WAIT, in_mem_ok=1: write data/tag[idx]=in_mem_data/miss tag and set valid[idx]; go to RESP.
//  - RESP: ok=1 and inst=filled word, unless squashed; then IDLE.
//  - Miss latency: at least 4 cycles plus memory time.
//    ena high at T -> ISSUE T+1 -> mem_ena T+1 (if not busy) -> ok >= 2 cycles after mem_ok.
//  - Flush:
//    - Sets a squash flag for the current transaction; it clears on return to IDLE.
//    - Flush in IDLE suppresses a hit answer in the following cycle.
//    - Flush in ISSUE returns to IDLE without issuing.
//    - Flush in WAIT or RESP: the fill still completes (address is valid); the ok pulse is suppressed.
//    - in_flush with in_mem_ok in the same cycle: line written, no ok.
//  - Fetcher holds in_fetch_addr stable while ena=1; the miss uses the latched address.
//  - in_mem_ok outside WAIT is ignored.
// CONFIGURATION
//  ICACHE_STATS_EN defined:
//  - out_hit_cnt and out_miss_cnt exist.
//  - Counters increment once per IDLE lookup resolving hit or miss (flushed lookups included).
//  - Counters wrap at 2^STAT_WIDTH and reset to 0.
//  Undefined: ports and counters are absent. Functional behaviour is identical.
// TESTING
//  - rst, fetch 0x100 -> miss: mem_ena pulse with addr 0x100.
//    mem_ok data 0xDEADBEEF -> fetch_ok inst 0xDEADBEEF.
//  - Refetch 0x100 -> ok next cycle, inst 0xDEADBEEF, no mem_ena.
//    With ICACHE_STATS_EN: hit=1, miss=1.
//  - Conflict: fetch 0x100 then 0x200 (same index, INDEX_BITS=6) -> both miss.
//    Refetch 0x100 misses again.
//  - mem_busy held 5 cycles during ISSUE -> no mem_ena until busy=0, then exactly one pulse.
//  - Flush in WAIT -> no fetch_ok. Refetch same addr -> hit, inst = filled value.
//  - rst in WAIT, then late mem_ok -> ignored. Refetch -> miss.

Source files
------------

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache, one 32-bit word per line.
// Sits between the fetcher and the byte-serial memory controller's icache port.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_flush,
  input  logic                  in_fetch_ena,
  input  logic [31:0]           in_fetch_addr,
  output logic                  out_fetch_ok,
  output logic [31:0]           out_fetch_inst,
  output logic                  out_mem_ena,
  output logic [31:0]           out_mem_addr,
  input  logic                  in_mem_busy,
  input  logic                  in_mem_ok,
  input  logic [31:0]           in_mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] out_hit_cnt,
  output logic [STAT_WIDTH-1:0] out_miss_cnt
`endif
);

  localparam int unsigned LINES = 1 << INDEX_BITS;
  localparam int unsigned TAG_W = 32 - INDEX_BITS - 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t state, state_next;

  // Line storage; only the valid bits are cleared by reset.
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic        squash, squash_next;
  logic [31:0] miss_addr, miss_addr_next;

  logic        fetch_ok_next;
  logic [31:0] fetch_inst_next;
  logic        mem_ena_next;
  logic [31:0] mem_addr_next;
  logic        fill_we;
  logic        lookup;
  logic        lookup_hit;

  logic [INDEX_BITS-1:0] fetch_idx;
  logic [INDEX_BITS-1:0] miss_idx;
  logic [TAG_W-1:0]      fetch_tag;
  logic [TAG_W-1:0]      miss_tag;
  logic                  tag_match_c;

  // Byte offset of the fetch PC carries no information for word fetches.
  logic unused_addr_bits;
  assign unused_addr_bits = ^in_fetch_addr[1:0];

  assign fetch_idx   = in_fetch_addr[INDEX_BITS+1:2];
  assign fetch_tag   = in_fetch_addr[31:INDEX_BITS+2];
  assign miss_idx    = miss_addr[INDEX_BITS+1:2];
  assign miss_tag    = miss_addr[31:INDEX_BITS+2];
  assign tag_match_c = valid[fetch_idx] && (tag_mem[fetch_idx] == fetch_tag);

  // Next-state and registered-output decode.
  always_comb begin
    state_next      = state;
    squash_next     = squash;
    miss_addr_next  = miss_addr;
    fetch_ok_next   = 1'b0;
    fetch_inst_next = 32'h0;
    mem_ena_next    = 1'b0;
    mem_addr_next   = out_mem_addr;
    fill_we         = 1'b0;
    lookup          = 1'b0;
    lookup_hit      = 1'b0;

    case (state)
      ST_IDLE: begin
        squash_next = 1'b0;
        // The request is still high during the ok cycle; it was already served.
        if (in_fetch_ena && !out_fetch_ok) begin
          lookup = 1'b1;
          if (tag_match_c) begin
            lookup_hit = 1'b1;
            if (!in_flush) begin
              fetch_ok_next   = 1'b1;
              fetch_inst_next = data_mem[fetch_idx];
            end
          end else begin
            miss_addr_next = {in_fetch_addr[31:2], 2'b00};
            squash_next    = in_flush;
            state_next     = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // Nothing is outstanding yet, so a squashed miss is simply dropped.
        if (in_flush || squash) begin
          squash_next = 1'b0;
          state_next  = ST_IDLE;
        end else if (!in_mem_busy) begin
          mem_ena_next  = 1'b1;
          mem_addr_next = miss_addr;
          state_next    = ST_WAIT;
        end
      end

      ST_WAIT: begin
        // The read is in flight; a flush only suppresses the answer.
        if (in_flush) begin
          squash_next = 1'b1;
        end
        if (in_mem_ok) begin
          fill_we    = 1'b1;
          state_next = ST_RESP;
        end
      end

      ST_RESP: begin
        if (!(squash || in_flush)) begin
          fetch_ok_next   = 1'b1;
          fetch_inst_next = data_mem[miss_idx];
        end
        squash_next = 1'b0;
        state_next  = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State, control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      squash         <= 1'b0;
      miss_addr      <= 32'h0;
      out_fetch_ok   <= 1'b0;
      out_fetch_inst <= 32'h0;
      out_mem_ena    <= 1'b0;
      out_mem_addr   <= 32'h0;
      valid          <= '0;
    end else begin
      state          <= state_next;
      squash         <= squash_next;
      miss_addr      <= miss_addr_next;
      out_fetch_ok   <= fetch_ok_next;
      out_fetch_inst <= fetch_inst_next;
      out_mem_ena    <= mem_ena_next;
      out_mem_addr   <= mem_addr_next;
      if (fill_we) begin
        valid[miss_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays are written on fill only and carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && fill_we) begin
      tag_mem[miss_idx]  <= miss_tag;
      data_mem[miss_idx] <= in_mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // One count per resolved IDLE lookup, flushed lookups included.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_hit_cnt  <= '0;
      out_miss_cnt <= '0;
    end else if (lookup) begin
      if (lookup_hit) begin
        out_hit_cnt <= out_hit_cnt + STAT_WIDTH'(1);
      end else begin
        out_miss_cnt <= out_miss_cnt + STAT_WIDTH'(1);
      end
    end
  end
`else
  logic unused_stats;
  logic [STAT_WIDTH-1:0] unused_stat_width;
  assign unused_stat_width = '0;
  assign unused_stats = lookup ^ lookup_hit ^ (^unused_stat_width);
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb_icache_direct: directed bench for icache_direct with a fetch-answer scoreboard.
// Build with ICACHE_STATS_EN defined to also check the hit/miss counters.
module tb_icache_direct;

  logic        clk;
  logic        rst;
  logic        in_flush;
  logic        in_fetch_ena;
  logic [31:0] in_fetch_addr;
  logic        out_fetch_ok;
  logic [31:0] out_fetch_inst;
  logic        out_mem_ena;
  logic [31:0] out_mem_addr;
  logic        in_mem_busy;
  logic        in_mem_ok;
  logic [31:0] in_mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] out_hit_cnt;
  logic [31:0] out_miss_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  bit mon_en = 0;
  logic [31:0] exp_q[$];

  icache_direct dut (
    .clk            (clk),
    .rst            (rst),
    .in_flush       (in_flush),
    .in_fetch_ena   (in_fetch_ena),
    .in_fetch_addr  (in_fetch_addr),
    .out_fetch_ok   (out_fetch_ok),
    .out_fetch_inst (out_fetch_inst),
    .out_mem_ena    (out_mem_ena),
    .out_mem_addr   (out_mem_addr),
    .in_mem_busy    (in_mem_busy),
    .in_mem_ok      (in_mem_ok),
    .in_mem_data    (in_mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .out_hit_cnt    (out_hit_cnt),
    .out_miss_cnt   (out_miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ok pulse pops one expected instruction; no ok means inst is zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_fetch_ok) begin
        if (exp_q.size() == 0) begin
          chk({31'h0, out_fetch_ok}, 32'h0, "unexpected_fetch_ok");
        end else begin
          chk(out_fetch_inst, exp_q.pop_front(), "fetch_inst");
        end
      end else begin
        chk(out_fetch_inst, 32'h0, "inst_zero_when_idle");
      end
    end
  end

  // One fetch transaction. mode: 0 normal, 1 flush in WAIT, 2 flush with mem_ok,
  // 3 flush with the request (IDLE), 4 flush in ISSUE, 5 reset in WAIT.
  // On a miss the bench memory returns inst; on a hit inst is the cached word.
  task automatic fetch(input logic [31:0] addr, input bit miss, input logic [31:0] inst,
                       input int busy_cyc, input int mode, input string tag);
    int cyc = 0;
    int ena_cyc = -1;
    int ena_cnt = 0;
    int ok_cyc = -1;
    int mem_ok_cyc = -1;
    bit done = 0;
    @(negedge clk);
    in_fetch_ena  = 1'b1;
    in_fetch_addr = addr;
    in_mem_busy   = (busy_cyc > 0);
    if (mode == 3) in_flush = 1'b1;
    if (mode == 0) exp_q.push_back(inst);
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      in_flush    = 1'b0;
      in_mem_ok   = 1'b0;
      in_mem_data = 32'h0;
      rst         = 1'b0;
      if (busy_cyc > 0 && cyc == busy_cyc) in_mem_busy = 1'b0;
      if (mode == 3) in_fetch_ena = 1'b0;
      if (mode == 4 && cyc == 1) begin
        in_flush     = 1'b1;
        in_fetch_ena = 1'b0;
      end
      if (out_mem_ena) begin
        ena_cnt++;
        if (ena_cyc < 0) begin
          ena_cyc = cyc;
          chk(out_mem_addr, {addr[31:2], 2'b00}, {tag, "_mem_addr"});
          if (mode == 1) begin
            in_flush     = 1'b1;
            in_fetch_ena = 1'b0;
          end
          if (mode == 5) begin
            rst          = 1'b1;
            in_fetch_ena = 1'b0;
          end
        end
      end
      if (ena_cyc >= 0 && cyc == ena_cyc + 2) begin
        in_mem_ok   = 1'b1;
        in_mem_data = inst;
        mem_ok_cyc  = cyc;
        if (mode == 2) begin
          in_flush     = 1'b1;
          in_fetch_ena = 1'b0;
        end
      end
      if (out_fetch_ok) begin
        ok_cyc       = cyc;
        in_fetch_ena = 1'b0;
        done         = 1;
      end
      if (mode != 0 && cyc >= 12) done = 1;
    end
    in_fetch_ena = 1'b0;
    in_flush     = 1'b0;
    in_mem_ok    = 1'b0;
    in_mem_data  = 32'h0;
    in_mem_busy  = 1'b0;
    rst          = 1'b0;

    if (miss) exp_misses++;
    else exp_hits++;
    if (mode == 5) begin
      exp_hits   = 0;
      exp_misses = 0;
    end

    if (mode == 0) begin
      chk({31'h0, ok_cyc > 0}, 32'h1, {tag, "_ok_seen"});
      if (ok_cyc < 0) exp_q.delete();
    end else begin
      chk(32'(ok_cyc), 32'hFFFF_FFFF, {tag, "_ok_squashed"});
    end
    if (miss && mode != 3 && mode != 4) begin
      chk(32'(ena_cnt), 32'd1, {tag, "_mem_ena_pulses"});
      chk(32'(ena_cyc), 32'((busy_cyc > 0) ? busy_cyc + 1 : 2), {tag, "_mem_ena_cycle"});
      if (mode == 0) chk(32'(ok_cyc), 32'(mem_ok_cyc + 2), {tag, "_miss_latency"});
    end else begin
      chk(32'(ena_cnt), 32'd0, {tag, "_no_mem_ena"});
      if (mode == 0) chk(32'(ok_cyc), 32'd1, {tag, "_hit_latency"});
    end
  endtask

  initial begin
    rst           = 1'b1;
    in_flush      = 1'b0;
    in_fetch_ena  = 1'b0;
    in_fetch_addr = 32'h0;
    in_mem_busy   = 1'b0;
    in_mem_ok     = 1'b0;
    in_mem_data   = 32'h0;
    repeat (3) @(negedge clk);
    chk({31'h0, out_fetch_ok}, 32'h0, "rst_fetch_ok");
    chk(out_fetch_inst, 32'h0, "rst_fetch_inst");
    chk({31'h0, out_mem_ena}, 32'h0, "rst_mem_ena");
    chk(out_mem_addr, 32'h0, "rst_mem_addr");
`ifdef ICACHE_STATS_EN
    chk(out_hit_cnt, 32'h0, "rst_hit_cnt");
    chk(out_miss_cnt, 32'h0, "rst_miss_cnt");
`endif
    rst    = 1'b0;
    mon_en = 1'b1;

    fetch(32'h0000_0100, 1, 32'hDEAD_BEEF, 0, 0, "miss_100");
    fetch(32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 0, "hit_100");
`ifdef ICACHE_STATS_EN
    chk(out_hit_cnt, 32'd1, "stats_hit_after_refetch");
    chk(out_miss_cnt, 32'd1, "stats_miss_after_refetch");
`endif
    fetch(32'h0000_0104, 1, 32'h1111_0104, 0, 0, "miss_104");
    fetch(32'h0000_0200, 1, 32'h2222_0200, 0, 0, "conflict_200");
    fetch(32'h0000_0100, 1, 32'hDEAD_BEEF, 0, 0, "conflict_100_again");
    fetch(32'h0000_0106, 0, 32'h1111_0104, 0, 0, "hit_104_offset");
    fetch(32'h0000_03FC, 1, 32'h3333_03FC, 5, 0, "busy_3fc");
    fetch(32'h0000_03FC, 0, 32'h3333_03FC, 0, 0, "hit_3fc");
    fetch(32'h0000_0140, 1, 32'h4444_0140, 0, 1, "flush_wait_140");
    fetch(32'h0000_0140, 0, 32'h4444_0140, 0, 0, "hit_after_flush_140");
    fetch(32'h0000_0180, 1, 32'h5555_0180, 0, 2, "flush_memok_180");
    fetch(32'h0000_0180, 0, 32'h5555_0180, 0, 0, "hit_after_flush_180");
    fetch(32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 3, "flush_idle_hit_100");
    fetch(32'h0000_0100, 0, 32'hDEAD_BEEF, 0, 0, "hit_100_after_flush");
    fetch(32'h0000_01C0, 1, 32'h6666_01C0, 0, 4, "flush_issue_1c0");
    fetch(32'h0000_01C0, 1, 32'h6666_01C0, 0, 0, "miss_1c0_after_flush");
    fetch(32'h0000_0240, 1, 32'h7777_0240, 0, 5, "rst_wait_240");
    fetch(32'h0000_0240, 1, 32'h7777_0240, 0, 0, "miss_240_after_rst");
    fetch(32'h0000_0100, 1, 32'hDEAD_BEEF, 0, 0, "miss_100_after_rst");
`ifdef ICACHE_STATS_EN
    chk(out_hit_cnt, 32'(exp_hits), "stats_hit_final");
    chk(out_miss_cnt, 32'(exp_misses), "stats_miss_final");
`endif
    repeat (3) @(negedge clk);
    chk(32'(exp_q.size()), 32'd0, "scoreboard_drained");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
